// File: rtl/seven_seg_scanner_pkg.sv
// rtl/seven_seg_scanner_pkg.sv - glyph table, blank pattern and timing helpers for the scanner
package seven_seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // GFEDCBA, active-low; entry 0 is the rightmost element
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'b0001110,   // F
      7'b0000110,   // E
      7'b0100001,   // d
      7'b1000110,   // C
      7'b0000011,   // b
      7'b0001000,   // A
      7'b0011000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   function automatic int ticks_for(input int clk_hz, input int dwell_hz);
      return clk_hz / dwell_hz;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - display data inputs and pin outputs of the scanner
interface seven_seg_scanner_if #(
   parameter int N_DIGITS = 4
);
   logic [4*N_DIGITS-1:0] value;
   logic [N_DIGITS-1:0]   dp_in;
   logic [N_DIGITS-1:0]   digit_en;
   logic                  load;
   logic                  hex_en;
   logic                  blank_lz;
   logic [6:0]            seg;
   logic                  dp;
   logic [N_DIGITS-1:0]   an;
   logic                  frame_done;

   modport master (
      output value, dp_in, digit_en, load, hex_en, blank_lz,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  value, dp_in, digit_en, load, hex_en, blank_lz,
      output seg, dp, an, frame_done
   );
endinterface

// File: rtl/seg_glyph_lut.sv
// rtl/seg_glyph_lut.sv - nibble to active-low GFEDCBA pattern, with decimal-mode and forced blanking
module seg_glyph_lut
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_en,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank && (hex_en || (nibble < 4'd10))) begin
         seg = GLYPH_TABLE[nibble];
      end
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - N-digit multiplexed common-anode driver with frame-aligned data update
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int CLK_HZ       = 100_000_000,
   parameter int DWELL_HZ     = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seven_seg_scanner_if.slave   bus
);

   localparam int TICKS = ticks_for(CLK_HZ, DWELL_HZ);
   localparam int TW    = cnt_width(TICKS);
   localparam int IW    = cnt_width(N_DIGITS);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
   localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

   typedef struct packed {
      logic [4*N_DIGITS-1:0] value;
      logic [N_DIGITS-1:0]   dp;
      logic [N_DIGITS-1:0]   en;
   } shadow_t;

   localparam shadow_t SHADOW_RESET = '{value: '0, dp: '0, en: '1};

   logic [TW-1:0]       tick_cnt;
   logic [IW-1:0]       idx;
   shadow_t             pending;
   shadow_t             active;
   logic                slot_end;
   logic                wrap;

   logic [N_DIGITS-1:0] lz_blank;
   logic [3:0]          cur_nibble;
   logic                cur_dp;
   logic                cur_en;
   logic                cur_lz;
   logic [N_DIGITS-1:0] an_lit;
   logic [6:0]          glyph_seg;
   logic                lit;

   logic [6:0]          seg_q;
   logic                dp_q;
   logic [N_DIGITS-1:0] an_q;
   logic                frame_done_q;

   assign slot_end = (tick_cnt == TICK_LAST);
   assign wrap     = slot_end && (idx == IDX_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         idx      <= '0;
      end else if (slot_end) begin
         tick_cnt <= '0;
         idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // active only changes at the frame boundary so a frame never mixes old and new data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= SHADOW_RESET;
         active  <= SHADOW_RESET;
      end else begin
         if (bus.load) begin
            pending <= '{value: bus.value, dp: bus.dp_in, en: bus.digit_en};
         end
         if (wrap) begin
            active <= pending;
         end
      end
   end

   // scan from the top digit down; a digit is a leading zero while everything above it is zero
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      lz_blank   = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zero_above  = zero_above && (active.value[4*i +: 4] == 4'd0);
         lz_blank[i] = bus.blank_lz && zero_above && (i != 0);
      end
   end

   always_comb begin
      cur_nibble = '0;
      cur_dp     = 1'b0;
      cur_en     = 1'b0;
      cur_lz     = 1'b0;
      an_lit     = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_nibble = active.value[4*i +: 4];
            cur_dp     = active.dp[i];
            cur_en     = active.en[i];
            cur_lz     = lz_blank[i];
            an_lit[i]  = 1'b0;
         end
      end
   end

   seg_glyph_lut u_lut (
      .nibble (cur_nibble),
      .hex_en (bus.hex_en),
      .blank  (cur_lz),
      .seg    (glyph_seg)
   );

   assign lit = (tick_cnt >= BLANK_END) && cur_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         an_q         <= '1;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= wrap;
         if (lit) begin
            seg_q <= glyph_seg;
            dp_q  <= ~cur_dp;
            an_q  <= an_lit;
         end else begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= '1;
         end
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.an         = an_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed bench with a slot/frame arithmetic model checked every cycle
module tb_seven_seg_scanner;

   localparam int N      = 4;
   localparam int CLK_HZ = 1000;
   localparam int DW_HZ  = 100;
   localparam int BLANK  = 2;
   localparam int TICKS  = 10;
   localparam int FRAME  = N * TICKS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seven_seg_scanner_if #(.N_DIGITS(N)) bus();

   seven_seg_scanner #(
      .N_DIGITS     (N),
      .CLK_HZ       (CLK_HZ),
      .DWELL_HZ     (DW_HZ),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   function automatic logic [6:0] ref_glyph(input logic [3:0] n, input logic hex, input logic blank);
      if (blank || (!hex && n > 4'd9)) return 7'b1111111;
      case (n)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   // model: position within the frame, and the frame's data snapshot
   int          pos;
   int          slot;
   int          k;
   logic [15:0] m_val, p_val;
   logic [3:0]  m_dp, p_dp, m_en, p_en;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_an;
   logic        e_fd;
   logic        lz;
   bit          chk_en = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
         pos = 0;
         p_val = '0; m_val = '0; p_dp = '0; m_dp = '0; p_en = 4'hF; m_en = 4'hF;
         chk_en = 1'b1;
      end else begin
         slot = pos / TICKS;
         k    = pos % TICKS;
         e_fd = (pos == FRAME - 1);
         if (k < BLANK || !m_en[slot]) begin
            e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'hF;
         end else begin
            e_an  = 4'hF & ~(4'd1 << slot);
            e_dp  = ~m_dp[slot];
            lz    = bus.blank_lz && (slot != 0) && ((m_val >> (4 * slot)) == 16'd0);
            e_seg = ref_glyph(m_val[4*slot +: 4], bus.hex_en, lz);
         end
         if (pos == FRAME - 1) begin
            m_val = p_val; m_dp = p_dp; m_en = p_en;
         end
         if (bus.load) begin
            p_val = bus.value; p_dp = bus.dp_in; p_en = bus.digit_en;
         end
         pos = (pos + 1) % FRAME;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_chk++;
         if ({bus.seg, bus.dp, bus.an, bus.frame_done} === {e_seg, e_dp, e_an, e_fd}) begin
            n_pass++;
         end else begin
            $display("FAIL model t=%0t seg=%b/%b dp=%b/%b an=%b/%b fd=%b/%b (got/exp)",
                     $time, bus.seg, e_seg, bus.dp, e_dp, bus.an, e_an, bus.frame_done, e_fd);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
   endtask

   task automatic grab(input int d, output logic [6:0] s, output logic p);
      bit found;
      found = 1'b0;
      s = 7'h7F; p = 1'b1;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         @(negedge clk);
         if (bus.an == ~(4'd1 << d)) begin
            found = 1'b1; s = bus.seg; p = bus.dp;
         end
      end
      if (!found) check("grab_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_fd();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         @(negedge clk);
         if (bus.frame_done) found = 1'b1;
      end
      if (!found) check("fd_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
      bus.value = v; bus.dp_in = d; bus.digit_en = en; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic check_digits(input string name, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
      logic [6:0] s;
      logic       p;
      grab(0, s, p); check({name, "_d0"}, s, s0);
      grab(1, s, p); check({name, "_d1"}, s, s1);
      grab(2, s, p); check({name, "_d2"}, s, s2);
      grab(3, s, p); check({name, "_d3"}, s, s3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] s;
      logic       p;
      int         cnt, low02, low1, low3, fds;

      bus.value = '0; bus.dp_in = '0; bus.digit_en = 4'hF; bus.load = 1'b0;
      bus.hex_en = 1'b1; bus.blank_lz = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_seg", bus.seg, 7'b1111111);
      check("rst_an", bus.an, 4'hF);
      check("rst_dp_fd", {bus.dp, bus.frame_done}, 2'b10);
      rst_n = 1'b1;

      // idle: zero glyph on every slot, frame_done every FRAME cycles
      wait_fd();
      cnt = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         cnt++;
         if (bus.frame_done) break;
      end
      check("fd_period", cnt, FRAME);
      check_digits("idle", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

      // mid-frame load must not tear the current frame
      grab(0, s, p);
      do_load(16'h1234, 4'b0100, 4'hF);
      grab(2, s, p); check("tear_d2", s, 7'b1000000);
      grab(3, s, p); check("tear_d3", s, 7'b1000000);
      grab(0, s, p); check("n1234_d0", s, 7'b0011001); check("n1234_dp0", p, 1'b1);
      grab(1, s, p); check("n1234_d1", s, 7'b0110000);
      grab(2, s, p); check("n1234_d2", s, 7'b0100100); check("n1234_dp2", p, 1'b0);
      grab(3, s, p); check("n1234_d3", s, 7'b1111001);

      bus.blank_lz = 1'b1;
      do_load(16'h00A5, 4'b0000, 4'hF);
      wait_fd(); wait_fd();
      check_digits("a5_hex", 7'b0010010, 7'b0001000, 7'b1111111, 7'b1111111);
      bus.hex_en = 1'b0;
      grab(0, s, p); check("a5_dec_d0", s, 7'b0010010);
      grab(1, s, p); check("a5_dec_d1", s, 7'b1111111);
      bus.hex_en = 1'b1;

      do_load(16'h0000, 4'b0000, 4'hF);
      wait_fd(); wait_fd();
      check_digits("zero_lz", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);

      // disabled digits keep their slot time but never light
      bus.blank_lz = 1'b0;
      do_load(16'h0000, 4'b0000, 4'b1010);
      wait_fd(); wait_fd();
      low02 = 0; low1 = 0; low3 = 0; fds = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (!bus.an[0] || !bus.an[2]) low02++;
         if (!bus.an[1]) low1++;
         if (!bus.an[3]) low3++;
         if (bus.frame_done) fds++;
      end
      check("en_low02", low02, 0);
      check("en_low1", low1, TICKS - BLANK);
      check("en_low3", low3, TICKS - BLANK);
      check("en_fds", fds, 1);

      // reset mid-slot of digit 2
      do_load(16'h0000, 4'b0000, 4'hF);
      wait_fd(); wait_fd();
      grab(2, s, p);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_seg", bus.seg, 7'b1111111);
      check("mrst_an_dp_fd", {bus.an, bus.dp, bus.frame_done}, 6'b111110);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 2 * TICKS; i++) begin
         @(negedge clk);
         cnt++;
         if (bus.an != 4'hF) break;
      end
      check("mrst_first_cycle", cnt, 3);
      check("mrst_first_an", bus.an, 4'b1110);
      repeat (FRAME) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Multiplexed driver for an N-digit common-anode seven-segment display. It captures a packed nibble word and scans the digits one at a time with a programmable per-digit dwell. It supports hex or decimal glyphs, per-digit enable, per-digit decimal points, leading-zero blanking and anti-ghost dead time. It sits between the classifier result logic and the board display pins, replacing single-digit decoding.

## Interface
- N_DIGITS, 4, number of digits scanned (1..8)
- CLK_HZ, 100_000_000, clk frequency
- DWELL_HZ, 1000, per-digit slot rate; TICKS = CLK_HZ/DWELL_HZ cycles per slot, TICKS ≥ BLANK_CYCLES+2
- BLANK_CYCLES, 16, dead-time cycles at the start of each slot with all anodes off
- clk  input  1  system clock
- rst_n  input  1  synchronous, active-low reset
- value  input  4*N_DIGITS  packed nibbles, digit 0 = bits [3:0] (least significant)
- dp_in  input  N_DIGITS  decimal point request per digit
- digit_en  input  N_DIGITS  1 = digit may light
- load  input  1  capture value/dp_in/digit_en into pending register
- hex_en  input  1  1 = hex glyphs, 0 = decimal (nibble > 9 blanks)
- blank_lz  input  1  suppress leading zeros
- seg  output  7  cathodes, active-low, GFEDCBA (bit 6 = G)
- dp  output  1  decimal point cathode, active-low
- an  output  N_DIGITS  anodes, active-low, one-hot-low or all high
- frame_done  output  1  one-cycle pulse when the scan wraps to digit 0

## Operation
- Registers: pending {value, dp_in, digit_en}, active copy of the same, tick_cnt 0..TICKS-1, idx 0..N_DIGITS-1.
- load=1: pending ← inputs. active ← pending only on the wrap cycle (tick_cnt=TICKS-1, idx=N_DIGITS-1). This prevents tearing mid-frame.
- load on the wrap cycle: active takes the old pending. The new data is displayed from the following frame.
- tick_cnt increments each cycle. At TICKS-1 it clears and idx advances, wrapping N_DIGITS-1 → 0. frame_done=1 on that wrap cycle.
- Glyphs (GFEDCBA, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- hex_en=0 and nibble ≥ 10: seg=1111111.
- Leading-zero blank: with blank_lz=1, digit i is blanked if it and every digit above it are 0 and i≠0. Digit 0 always shows. A blanked digit still drives dp if its dp bit is set.
- Digit with digit_en[i]=0: an[i] held high for its whole slot (slot time preserved, no skipping).
- Dead time: while tick_cnt < BLANK_CYCLES, an = all ones, seg=1111111, dp=1.
- hex_en and blank_lz are read live, not shadowed.

## Timing
- Reset values: seg=7'b1111111, dp=1, an=all ones, frame_done=0, tick_cnt=0, idx=0.
- Pending and active reset to value=0, dp=0, digit_en=all ones.
- Outputs are registered, with one cycle of latency from (tick_cnt, idx) to the pins.
- An anode goes low at slot cycle BLANK_CYCLES+1 and returns high at slot cycle 1 of the next slot.
- frame_done is registered with the same one-cycle latency.
- Frame period = N_DIGITS*TICKS cycles.
- Reset asserted mid-slot: all outputs take reset values on the next edge. Scanning restarts at idx 0, tick 0.

## Structure
- Package seven_seg_pkg: the 16-entry glyph constant table, SEG_BLANK=7'b1111111, and the TICKS derivation function.
- Sub-module seg_glyph_lut: combinational (nibble, hex_en, blank) → seg[6:0].
- The scanner holds the counters, the shadow registers, LZ logic and output registers.

## Test plan
All scenarios use N_DIGITS=4, CLK_HZ=1000, DWELL_HZ=100 (TICKS=10), BLANK_CYCLES=2.
- Reset, then idle 40 cycles: an cycles 1110→1101→1011→0111 with 2-cycle all-high gaps. seg=1000000 on every lit slot. frame_done pulses every 40 cycles.
- load value=16'h1234, dp_in=4'b0100 mid-frame: current frame still shows 0. The next frame shows digit0=0011001, digit1=0110000, digit2=0100100 with dp=0, digit3=1111001.
- value=16'h00A5: with hex_en=1 and blank_lz=1, digits 3 and 2 are blank, digit1=0001000, digit0=0010010. With hex_en=0, digit1 is blank.
- value=16'h0000, blank_lz=1: only digit 0 lights, showing 1000000.
- digit_en=4'b1010: an[0] and an[2] never go low, and slot timing is unchanged.
- rst_n low for 1 cycle mid-slot of idx 2: the next cycle all outputs are at reset values, and the first lit anode after release is an[0] at cycle 3.
